// File: rtl/pcs_rx_lock_ber_mon.sv
// pcs_rx_lock_ber_mon: per-lane sync-header block lock with gearbox slip and windowed hi-BER monitor
module pcs_rx_lock_ber_mon #(
  parameter int LANE_N       = 4,
  parameter int HEAD_W       = 2,
  parameter int SH_CNT_N     = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT_N  = 2,
  parameter int BER_TIMER_N  = 156250,
  parameter int BER_CNT_MAX  = 97
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANE_N-1:0]        signal_v_i,
  input  logic [LANE_N-1:0]        valid_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  output logic [LANE_N-1:0]        slip_v_o,
  output logic [LANE_N-1:0]        lock_v_o,
  output logic [LANE_N-1:0]        hi_ber_o,
  output logic                     link_ok_o
);
  localparam int SW = $clog2(SH_CNT_N + 1);
  localparam int IW = $clog2(SH_INVLD_MAX + 1);
  localparam int WW = SLIP_WAIT_N > 0 ? $clog2(SLIP_WAIT_N + 1) : 1;
  localparam int TW = $clog2(BER_TIMER_N + 1);
  localparam int BW = $clog2(BER_CNT_MAX + 1);
  localparam logic [SW-1:0] SH_LAST = SW'(SH_CNT_N);
  localparam logic [IW-1:0] INV_MAX = IW'(SH_INVLD_MAX);
  localparam logic [TW-1:0] TMR_LAST = TW'(BER_TIMER_N - 1);
  localparam logic [BW-1:0] BER_MAX = BW'(BER_CNT_MAX);
  typedef enum logic [1:0] {S_INIT, S_TEST, S_SLIP, S_WAIT} state_t;
  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    state_t          st;
    logic            lock, slip, hb, bad;
    logic [HEAD_W-1:0] hd;
    logic [SW-1:0]   sh_cnt, sh_nxt;
    logic [IW-1:0]   invld_cnt, inv_nxt;
    logic [WW-1:0]   wait_cnt;
    logic [TW-1:0]   tmr;
    logic [BW-1:0]   ber_cnt, ber_tot;
    // decode the sampled header and precompute next counter values
    always_comb begin
      hd = head_i[l*HEAD_W +: HEAD_W];
      bad = valid_i[l] & ~(hd == HEAD_W'(1) || hd == HEAD_W'(2));
      sh_nxt = sh_cnt + SW'(1);
      inv_nxt = invld_cnt + IW'(bad);
      ber_tot = (ber_cnt == BER_MAX) ? ber_cnt : ber_cnt + BW'(bad);
    end
    // lock FSM: test sync headers, request a slip on failure, then let the gearbox settle
    always_ff @(posedge clk) begin
      if (reset || !signal_v_i[l]) begin
        st        <= S_INIT;
        lock      <= 1'b0;
        slip      <= 1'b0;
        sh_cnt    <= '0;
        invld_cnt <= '0;
        wait_cnt  <= '0;
      end else begin
        slip <= 1'b0;
        case (st)
          S_INIT: st <= S_TEST;
          S_TEST: if (valid_i[l]) begin
            if (lock ? inv_nxt == INV_MAX : bad) begin
              st        <= S_SLIP;
              slip      <= 1'b1;
              lock      <= 1'b0;
              sh_cnt    <= '0;
              invld_cnt <= '0;
            end else if (sh_nxt == SH_LAST) begin
              lock      <= 1'b1;
              sh_cnt    <= '0;
              invld_cnt <= '0;
            end else begin
              sh_cnt    <= sh_nxt;
              invld_cnt <= inv_nxt;
            end
          end
          S_SLIP: begin
            st       <= (SLIP_WAIT_N == 0) ? S_TEST : S_WAIT;
            wait_cnt <= '0;
          end
          default: if (valid_i[l]) begin
            if (32'(wait_cnt) + 1 >= SLIP_WAIT_N) begin
              st       <= S_TEST;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end
        endcase
      end
    end
    // BER window: count invalid samples while locked, judge hi_ber at saturation or window end
    always_ff @(posedge clk) begin
      if (reset || !lock) begin
        tmr     <= '0;
        ber_cnt <= '0;
        hb      <= 1'b0;
      end else if (tmr == TMR_LAST) begin
        tmr     <= '0;
        ber_cnt <= '0;
        hb      <= ber_tot == BER_MAX;
      end else begin
        tmr     <= tmr + TW'(1);
        ber_cnt <= ber_tot;
        hb      <= hb | (ber_tot == BER_MAX);
      end
    end
    assign slip_v_o[l] = slip;
    assign lock_v_o[l] = lock;
    assign hi_ber_o[l] = hb;
  end
  // aggregate link status, one cycle behind the lane outputs
  always_ff @(posedge clk) begin
    link_ok_o <= reset ? 1'b0 : (&lock_v_o & ~|hi_ber_o);
  end
endmodule

// File: tb/tb_pcs_rx_lock_ber_mon.sv
// tb_pcs_rx_lock_ber_mon: randomized bench against a sample-counting reference model
module tb_pcs_rx_lock_ber_mon;
  localparam int SHN = 64, IMX = 16, SWN = 2, BTN = 1000, BCM = 97;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] signal_v_i = '0, valid_i = '0;
  logic [7:0] head_i = '0;
  logic [3:0] slip_v_o, lock_v_o, hi_ber_o;
  logic link_ok_o;
  int n_tests = 0, n_fail = 0;
  pcs_rx_lock_ber_mon #(.LANE_N(4), .HEAD_W(2), .SH_CNT_N(SHN), .SH_INVLD_MAX(IMX),
    .SLIP_WAIT_N(SWN), .BER_TIMER_N(BTN), .BER_CNT_MAX(BCM)) dut (
    .clk(clk), .reset(reset), .signal_v_i(signal_v_i), .valid_i(valid_i), .head_i(head_i),
    .slip_v_o(slip_v_o), .lock_v_o(lock_v_o), .hi_ber_o(hi_ber_o), .link_ok_o(link_ok_o));
  always #5 clk = ~clk;
  int m_cnt[4], m_bad[4], m_skip[4], m_tmr[4], m_bc[4];
  bit m_init[4] = '{1, 1, 1, 1}, m_hold[4];
  logic [3:0] e_lock = '0, e_slip = '0, e_hb = '0;
  logic e_ok = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step_model();
    logic [3:0] ol, oh;
    logic [1:0] hd;
    bit v, inv;
    int tot;
    ol = e_lock;
    oh = e_hb;
    e_ok = !reset && (&ol) && !(|oh);
    for (int l = 0; l < 4; l++) begin
      hd = head_i[l*2 +: 2];
      v = valid_i[l];
      inv = v && !(hd == 2'b01 || hd == 2'b10);
      if (reset || !ol[l]) begin
        m_tmr[l] = 0; m_bc[l] = 0; e_hb[l] = 1'b0;
      end else begin
        tot = (m_bc[l] + int'(inv) > BCM) ? BCM : m_bc[l] + int'(inv);
        if (m_tmr[l] == BTN - 1) begin
          m_tmr[l] = 0; m_bc[l] = 0; e_hb[l] = (tot >= BCM);
        end else begin
          m_tmr[l]++; m_bc[l] = tot;
          if (tot >= BCM) e_hb[l] = 1'b1;
        end
      end
      e_slip[l] = 1'b0;
      if (reset || !signal_v_i[l]) begin
        e_lock[l] = 1'b0; m_cnt[l] = 0; m_bad[l] = 0; m_skip[l] = 0; m_hold[l] = 0; m_init[l] = 1;
      end else if (m_init[l]) m_init[l] = 0;
      else if (m_hold[l]) m_hold[l] = 0;
      else if (v) begin
        if (m_skip[l] > 0) m_skip[l]--;
        else begin
          m_cnt[l]++;
          m_bad[l] += int'(inv);
          if (e_lock[l] ? (m_bad[l] >= IMX) : inv) begin
            e_slip[l] = 1'b1; e_lock[l] = 1'b0; m_hold[l] = 1; m_skip[l] = SWN; m_cnt[l] = 0; m_bad[l] = 0;
          end else if (m_cnt[l] == SHN) begin
            e_lock[l] = 1'b1; m_cnt[l] = 0; m_bad[l] = 0;
          end
        end
      end
    end
  endtask
  task automatic tick(input logic [3:0] v, input logic [3:0] bad);
    valid_i = v;
    for (int l = 0; l < 4; l++)
      head_i[l*2 +: 2] = bad[l] ? ($urandom_range(1) ? 2'b11 : 2'b00) : ($urandom_range(1) ? 2'b10 : 2'b01);
    @(posedge clk);
    step_model();
    @(negedge clk);
    chk("slip", 32'(slip_v_o), 32'(e_slip));
    chk("lock", 32'(lock_v_o), 32'(e_lock));
    chk("hi_ber", 32'(hi_ber_o), 32'(e_hb));
    chk("link_ok", 32'(link_ok_o), 32'(e_ok));
  endtask
  function automatic logic [3:0] rv();
    return 4'($urandom) | 4'($urandom);
  endfunction
  initial begin
    int nslip;
    logic [3:0] b;
    repeat (3) tick(4'hf, 4'h0);
    reset = 1'b0;
    signal_v_i = 4'hf;
    repeat (200) tick(rv() | 4'h1, 4'h0);
    chk("initial_lock", 32'(lock_v_o), 32'hf);
    signal_v_i[1] = 1'b0;
    tick(4'hf, 4'h0);
    signal_v_i[1] = 1'b1;
    repeat (10) tick(4'hf, 4'h0);
    tick(4'hf, 4'h2);
    nslip = int'(slip_v_o[1]);
    repeat (100) begin
      tick(4'hf, 4'h0);
      nslip += int'(slip_v_o[1]);
    end
    chk("lane1_slips", 32'(nslip), 32'd1);
    chk("lane1_relock", 32'(lock_v_o[1]), 32'd1);
    for (int i = 0; i < 64; i++) tick(4'hf, (i % 4 == 0 && i < 60) ? 4'h4 : 4'h0);
    chk("lane2_15bad", 32'(lock_v_o[2]), 32'd1);
    repeat (40) tick(4'hf, 4'h4);
    chk("lane2_16bad", 32'(lock_v_o[2]), 32'd0);
    repeat (120) tick(4'hf, 4'h0);
    chk("relock_all", 32'(lock_v_o), 32'hf);
    for (int i = 0; i < 2000; i++) tick(4'hf, (i % 8 == 0) ? 4'h8 : 4'h0);
    chk("lane3_hiber", 32'(hi_ber_o[3]), 32'd1);
    chk("lane3_lock", 32'(lock_v_o[3]), 32'd1);
    chk("link_down", 32'(link_ok_o), 32'd0);
    repeat (2100) tick(4'hf, 4'h0);
    chk("lane3_clear", 32'(hi_ber_o[3]), 32'd0);
    chk("link_up", 32'(link_ok_o), 32'd1);
    repeat (3000) begin
      for (int l = 0; l < 4; l++) b[l] = ($urandom_range(127) == 0);
      tick(rv(), b);
    end
    signal_v_i[0] = 1'b0;
    repeat (5) tick(rv(), 4'h0);
    chk("sig_drop_lock", 32'(lock_v_o[0]), 32'd0);
    signal_v_i[0] = 1'b1;
    repeat (30) tick(rv(), 4'h0);
    reset = 1'b1;
    tick(rv(), 4'h0);
    chk("rst_lock", 32'(lock_v_o), 32'd0);
    chk("rst_link", 32'(link_ok_o), 32'd0);
    reset = 1'b0;
    repeat (200) tick(rv(), 4'h0);
    chk("final_lock", 32'(lock_v_o), 32'hf);
    chk("final_link", 32'(link_ok_o), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
